// File: rtl/vec_lsu.sv
// ---------------------------------------------------------------------------
// vec_lsu : multi-beat vector load/store sequencer
//
// Moves one LANES-lane vector between the word-wide data memory and the
// vector register file, one lane per clock. A load gathers words from memory
// into an internal buffer and then writes the whole vector to the register
// file in one commit cycle. A store scatters a buffered snapshot of a vector
// register into memory. The walk is strided and each lane can be masked off.
// Lane 0 occupies the MSBs of a packed vector and lane LANES-1 the LSBs.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   reset         : synchronous, active-high
//   start         : request, sampled only while idle
//   op            : 0 = load (mem -> vreg), 1 = store (vreg -> mem)
//   base_addr     : byte address of lane 0
//   stride        : byte increment between lanes (0 allowed)
//   vreg          : vector register index
//   lane_mask     : bit i enables lane i
//   busy          : high whenever the sequencer is not idle
//   done          : one-cycle completion pulse
//   mem_addr      : address presented to memory (holds outside beats)
//   mem_wr_en     : memory write strobe
//   mem_data_out  : store data
//   mem_data_in   : memory read data, combinational from mem_addr
//   vreg_rd_addr  : combinational pass-through of vreg
//   vreg_rd_data  : vector register read data, combinational
//   vreg_wr_en    : vector register write strobe
//   vreg_wr_addr  : vector register write index
//   vreg_wr_data  : vector register write data
// ---------------------------------------------------------------------------
module vec_lsu #(
  parameter int LANES   = 4,
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int VREG_AW = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      op,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         stride,
  input  logic [VREG_AW-1:0]        vreg,
  input  logic [LANES-1:0]          lane_mask,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr_en,
  output logic [WORD_W-1:0]         mem_data_out,
  input  logic [WORD_W-1:0]         mem_data_in,
  output logic [VREG_AW-1:0]        vreg_rd_addr,
  input  logic [LANES*WORD_W-1:0]   vreg_rd_data,
  output logic                      vreg_wr_en,
  output logic [VREG_AW-1:0]        vreg_wr_addr,
  output logic [LANES*WORD_W-1:0]   vreg_wr_data
);

  // A single-lane vector still needs a one-bit counter to keep the
  // declarations legal; it simply never leaves zero.
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BUF_W = LANES * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_COMMIT,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic                r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_stride;
  logic [VREG_AW-1:0]  r_vreg;
  logic [LANES-1:0]    r_mask;
  logic [BUF_W-1:0]    r_buf;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_lastBeat;
  logic                w_laneEn;
  logic [WORD_W-1:0]   w_laneData;

  assign w_lastBeat   = (r_cnt == CNT_W'(LANES - 1));
  assign vreg_rd_addr = vreg;

  // Select the mask bit and buffered word of the lane handled in this beat.
  // A decode loop keeps every part select constant, which works for any
  // LANES including 1.
  always_comb begin
    w_laneEn   = 1'b0;
    w_laneData = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_laneEn   = r_mask[i];
        w_laneData = r_buf[(LANES-1-i)*WORD_W +: WORD_W];
      end
    end
  end

  // Next-state logic. A start that arrives while busy is simply not looked
  // at; only IDLE samples it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_nextState = ST_BEAT;
      ST_BEAT:   if (w_lastBeat) w_nextState = r_op ? ST_DONE : ST_COMMIT;
      ST_COMMIT: w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Output decodes. Strobes come straight from the registered state, so
  // they can never fire in IDLE or DONE. Write data is zeroed outside the
  // cycle that qualifies it so idle outputs are quiet.
  always_comb begin
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
    mem_addr     = r_addr;
    mem_wr_en    = 1'b0;
    mem_data_out = '0;
    vreg_wr_en   = 1'b0;
    vreg_wr_addr = '0;
    vreg_wr_data = '0;
    if (r_state == ST_BEAT && r_op) begin
      mem_wr_en    = w_laneEn;
      mem_data_out = w_laneData;
    end
    if (r_state == ST_COMMIT) begin
      vreg_wr_en   = 1'b1;
      vreg_wr_addr = r_vreg;
      vreg_wr_data = r_buf;
    end
  end

  // State register and datapath. On start the request is latched and the
  // addressed register is snapshotted into the buffer: a load merges memory
  // words over that snapshot so masked lanes keep their old contents, and a
  // store sends the snapshot so later register writes cannot leak in.
  // The address accumulator stops advancing on the last beat so mem_addr
  // holds the final lane address afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= 1'b0;
      r_addr   <= '0;
      r_stride <= '0;
      r_vreg   <= '0;
      r_mask   <= '0;
      r_buf    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_addr   <= base_addr;
            r_stride <= stride;
            r_vreg   <= vreg;
            r_mask   <= lane_mask;
            r_buf    <= vreg_rd_data;
            r_cnt    <= '0;
          end
        end
        ST_BEAT: begin
          if (!r_op && w_laneEn) begin
            for (int i = 0; i < LANES; i++) begin
              if (r_cnt == CNT_W'(i)) begin
                r_buf[(LANES-1-i)*WORD_W +: WORD_W] <= mem_data_in;
              end
            end
          end
          if (!w_lastBeat) begin
            r_cnt  <= r_cnt + 1'b1;
            r_addr <= r_addr + r_stride;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lsu.sv
// ---------------------------------------------------------------------------
// tb_vec_lsu : scoreboard bench for vec_lsu
//
// Stimulus pushes the memory writes, register commits and done pulses it
// expects (with the cycle they must appear in) into queues; monitor
// processes pop and compare whenever a DUT strobe fires. Three instances
// are used: the default LANES=4/WORD_W=32 unit, plus LANES=8 and LANES=1
// units with WORD_W=16 for lane packing and latency.
//
// Mask literals use bit i = lane i, so a lane-0-first pattern such as
// "1010" is written 4'b0101.
// ---------------------------------------------------------------------------
module tb_vec_lsu;

  typedef struct {
    string        name;
    logic [31:0]  addr;
    logic [127:0] data;
    int           cyc;
  } expT;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [31:0]  baseAddr;
  logic [31:0]  stride;
  logic [4:0]   vreg;
  logic [3:0]   laneMask;
  logic         busy, done;
  logic [31:0]  memAddr;
  logic         memWrEn;
  logic [31:0]  memDataOut;
  logic [31:0]  memDataIn;
  logic [4:0]   vregRdAddr;
  logic [127:0] vregRdData;
  logic         vregWrEn;
  logic [4:0]   vregWrAddr;
  logic [127:0] vregWrData;

  logic         start8, start1;
  logic         busy8, busy1, done8, done1;
  logic [31:0]  mem8Addr, mem1Addr;
  logic         mem8WrEn, mem1WrEn;
  logic [15:0]  mem8Out, mem1Out, mem8In, mem1In;
  logic [4:0]   vreg8RdAddr, vreg1RdAddr, vreg8WrAddr, vreg1WrAddr;
  logic         vreg8WrEn, vreg1WrEn;
  logic [127:0] vreg8WrData;
  logic [15:0]  vreg1WrData;

  logic [31:0]  mem [256];
  logic [127:0] vrf [32];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  bit monOn = 1'b0;

  expT memQ[$], vregQ[$], doneQ[$], v8Q[$], d8Q[$], v1Q[$], d1Q[$];
  expT eM, eV, eD, e8, e1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory and register file models: combinational reads, contents set
  // directly by the stimulus.
  assign memDataIn  = mem[memAddr[9:2]];
  assign vregRdData = vrf[vregRdAddr];
  assign mem8In     = mem8Addr[17:2] + 16'h1000;
  assign mem1In     = mem1Addr[17:2] + 16'h1000;

  vec_lsu #(.LANES(4), .WORD_W(32), .ADDR_W(32), .VREG_AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .base_addr(baseAddr), .stride(stride), .vreg(vreg), .lane_mask(laneMask),
    .busy(busy), .done(done), .mem_addr(memAddr), .mem_wr_en(memWrEn),
    .mem_data_out(memDataOut), .mem_data_in(memDataIn),
    .vreg_rd_addr(vregRdAddr), .vreg_rd_data(vregRdData),
    .vreg_wr_en(vregWrEn), .vreg_wr_addr(vregWrAddr), .vreg_wr_data(vregWrData)
  );

  vec_lsu #(.LANES(8), .WORD_W(16), .ADDR_W(32), .VREG_AW(5)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(1'b0),
    .base_addr(32'h40), .stride(32'h4), .vreg(5'd2), .lane_mask(8'hF7),
    .busy(busy8), .done(done8), .mem_addr(mem8Addr), .mem_wr_en(mem8WrEn),
    .mem_data_out(mem8Out), .mem_data_in(mem8In),
    .vreg_rd_addr(vreg8RdAddr), .vreg_rd_data({8{16'hFFFF}}),
    .vreg_wr_en(vreg8WrEn), .vreg_wr_addr(vreg8WrAddr), .vreg_wr_data(vreg8WrData)
  );

  vec_lsu #(.LANES(1), .WORD_W(16), .ADDR_W(32), .VREG_AW(5)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(1'b0),
    .base_addr(32'h80), .stride(32'h4), .vreg(5'd7), .lane_mask(1'b1),
    .busy(busy1), .done(done1), .mem_addr(mem1Addr), .mem_wr_en(mem1WrEn),
    .mem_data_out(mem1Out), .mem_data_in(mem1In),
    .vreg_rd_addr(vreg1RdAddr), .vreg_rd_data(16'hBEEF),
    .vreg_wr_en(vreg1WrEn), .vreg_wr_addr(vreg1WrAddr), .vreg_wr_data(vreg1WrData)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic expT mk(input string n, input logic [31:0] a, input logic [127:0] d, input int c);
    expT e;
    e.name = n;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    return e;
  endfunction

  function automatic logic [127:0] p4(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {a, b, c, d};
  endfunction

  // Called just after a rising edge; start is seen by the next edge.
  // sCyc is the cycle count before that edge, so beat i is observed at
  // cycle sCyc+1+i.
  task automatic applyStimulus(input logic opI, input logic [31:0] b, input logic [31:0] s,
                               input logic [4:0] v, input logic [3:0] m, output int sCyc);
    op       = opI;
    baseAddr = b;
    stride   = s;
    vreg     = v;
    laneMask = m;
    start    = 1'b1;
    sCyc     = cyc;
    @(posedge clk);
    #2;
    start    = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Main-unit monitor: every strobe must match the head of its queue,
  // including the cycle it appears in; a strobe with an empty queue fails.
  always @(negedge clk) begin
    if (monOn) begin
      if (memWrEn !== 1'b0) begin
        if (memQ.size() == 0) checkOutput("unexpected_mem_wr", 128'(memWrEn), 128'd0);
        else begin
          eM = memQ.pop_front();
          checkOutput({eM.name, "_addr"}, 128'(memAddr), 128'(eM.addr));
          checkOutput({eM.name, "_data"}, 128'(memDataOut), eM.data);
          checkOutput({eM.name, "_cyc"}, 128'(cyc), 128'(eM.cyc));
        end
      end
      if (vregWrEn !== 1'b0) begin
        if (vregQ.size() == 0) checkOutput("unexpected_vreg_wr", 128'(vregWrEn), 128'd0);
        else begin
          eV = vregQ.pop_front();
          checkOutput({eV.name, "_addr"}, 128'(vregWrAddr), 128'(eV.addr));
          checkOutput({eV.name, "_data"}, vregWrData, eV.data);
          checkOutput({eV.name, "_cyc"}, 128'(cyc), 128'(eV.cyc));
        end
      end
      if (done !== 1'b0) begin
        if (doneQ.size() == 0) checkOutput("unexpected_done", 128'(done), 128'd0);
        else begin
          eD = doneQ.pop_front();
          checkOutput({eD.name, "_cyc"}, 128'(cyc), 128'(eD.cyc));
          checkOutput({eD.name, "_busy"}, 128'(busy), 128'd1);
        end
      end
    end
  end

  // Monitor for the LANES=8 and LANES=1 units.
  always @(negedge clk) begin
    if (monOn) begin
      if (vreg8WrEn !== 1'b0 || done8 !== 1'b0 || mem8WrEn !== 1'b0) begin
        if (mem8WrEn !== 1'b0) checkOutput("l8_unexpected_mem_wr", 128'(mem8WrEn), 128'd0);
        if (vreg8WrEn !== 1'b0) begin
          if (v8Q.size() == 0) checkOutput("l8_unexpected_vreg_wr", 128'(vreg8WrEn), 128'd0);
          else begin
            e8 = v8Q.pop_front();
            checkOutput({e8.name, "_addr"}, 128'(vreg8WrAddr), 128'(e8.addr));
            checkOutput({e8.name, "_data"}, vreg8WrData, e8.data);
            checkOutput({e8.name, "_cyc"}, 128'(cyc), 128'(e8.cyc));
          end
        end
        if (done8 !== 1'b0) begin
          if (d8Q.size() == 0) checkOutput("l8_unexpected_done", 128'(done8), 128'd0);
          else begin
            e8 = d8Q.pop_front();
            checkOutput({e8.name, "_cyc"}, 128'(cyc), 128'(e8.cyc));
          end
        end
      end
      if (vreg1WrEn !== 1'b0) begin
        if (v1Q.size() == 0) checkOutput("l1_unexpected_vreg_wr", 128'(vreg1WrEn), 128'd0);
        else begin
          e1 = v1Q.pop_front();
          checkOutput({e1.name, "_addr"}, 128'(vreg1WrAddr), 128'(e1.addr));
          checkOutput({e1.name, "_data"}, 128'(vreg1WrData), e1.data);
          checkOutput({e1.name, "_cyc"}, 128'(cyc), 128'(e1.cyc));
        end
      end
      if (done1 !== 1'b0) begin
        if (d1Q.size() == 0) checkOutput("l1_unexpected_done", 128'(done1), 128'd0);
        else begin
          e1 = d1Q.pop_front();
          checkOutput({e1.name, "_cyc"}, 128'(cyc), 128'(e1.cyc));
        end
      end
    end
  end

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; op = 1'b0; baseAddr = '0; stride = '0;
    vreg = '0; laneMask = '0; start8 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    for (int i = 0; i < 32; i++) vrf[i] = '0;
    mem[64] = 32'h11; mem[65] = 32'h22; mem[66] = 32'h33; mem[67] = 32'h44;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_done", 128'(done), 128'd0);
    checkOutput("rst_mem_wr_en", 128'(memWrEn), 128'd0);
    checkOutput("rst_vreg_wr_en", 128'(vregWrEn), 128'd0);
    checkOutput("rst_mem_addr", 128'(memAddr), 128'd0);
    checkOutput("rst_mem_data_out", 128'(memDataOut), 128'd0);
    checkOutput("rst_vreg_wr_addr", 128'(vregWrAddr), 128'd0);
    checkOutput("rst_vreg_wr_data", vregWrData, 128'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    monOn = 1'b1;
    @(posedge clk); #2;

    $display("[TB] full load");
    applyStimulus(1'b0, 32'h100, 32'h4, 5'd3, 4'b1111, s);
    vregQ.push_back(mk("ld_full", 32'd3, p4(32'h11, 32'h22, 32'h33, 32'h44), s + 5));
    doneQ.push_back(mk("ld_full_done", 0, 0, s + 6));
    waitUntil(s + 9);

    $display("[TB] masked load");
    vrf[3] = p4(32'hA, 32'hB, 32'hC, 32'hD);
    applyStimulus(1'b0, 32'h100, 32'h4, 5'd3, 4'b0101, s);
    vregQ.push_back(mk("ld_mask", 32'd3, p4(32'h11, 32'hB, 32'h33, 32'hD), s + 5));
    doneQ.push_back(mk("ld_mask_done", 0, 0, s + 6));
    waitUntil(s + 9);

    $display("[TB] strided store, snapshot");
    vrf[5] = p4(32'h1, 32'h2, 32'h3, 32'h4);
    applyStimulus(1'b1, 32'h200, 32'h8, 5'd5, 4'b1011, s);
    vrf[5] = '1;
    memQ.push_back(mk("st_l0", 32'h200, 128'h1, s + 1));
    memQ.push_back(mk("st_l1", 32'h208, 128'h2, s + 2));
    memQ.push_back(mk("st_l3", 32'h218, 128'h4, s + 4));
    doneQ.push_back(mk("st_done", 0, 0, s + 5));
    waitUntil(s + 8);

    $display("[TB] stride 0 load");
    vrf[4] = '0;
    applyStimulus(1'b0, 32'h104, 32'h0, 5'd4, 4'b0111, s);
    vregQ.push_back(mk("ld_s0", 32'd4, p4(32'h22, 32'h22, 32'h22, 32'h0), s + 5));
    doneQ.push_back(mk("ld_s0_done", 0, 0, s + 6));
    waitUntil(s + 9);

    $display("[TB] wrapping store and load");
    vrf[6] = p4(32'h5, 32'h6, 32'h7, 32'h8);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h4, 5'd6, 4'b1111, s);
    memQ.push_back(mk("wr_l0", 32'hFFFF_FFFC, 128'h5, s + 1));
    memQ.push_back(mk("wr_l1", 32'h0, 128'h6, s + 2));
    memQ.push_back(mk("wr_l2", 32'h4, 128'h7, s + 3));
    memQ.push_back(mk("wr_l3", 32'h8, 128'h8, s + 4));
    doneQ.push_back(mk("wr_done", 0, 0, s + 5));
    waitUntil(s + 8);
    applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h4, 5'd8, 4'b1111, s);
    vregQ.push_back(mk("wl", 32'd8, p4(32'hDEAD_00FF, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002), s + 5));
    doneQ.push_back(mk("wl_done", 0, 0, s + 6));
    waitUntil(s + 9);

    $display("[TB] start during beats is ignored");
    applyStimulus(1'b0, 32'h100, 32'h4, 5'd3, 4'b1111, s);
    op = 1'b1; baseAddr = 32'h200; vreg = 5'd5; laneMask = 4'b1111; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    vregQ.push_back(mk("ign", 32'd3, p4(32'h11, 32'h22, 32'h33, 32'h44), s + 5));
    doneQ.push_back(mk("ign_done", 0, 0, s + 6));
    waitUntil(s + 10);

    $display("[TB] reset during store");
    vrf[5] = p4(32'h1, 32'h2, 32'h3, 32'h4);
    applyStimulus(1'b1, 32'h200, 32'h8, 5'd5, 4'b1111, s);
    memQ.push_back(mk("ab_l0", 32'h200, 128'h1, s + 1));
    memQ.push_back(mk("ab_l1", 32'h208, 128'h2, s + 2));
    memQ.push_back(mk("ab_l2", 32'h210, 128'h3, s + 3));
    waitUntil(s + 3);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 128'(busy), 128'd0);
    checkOutput("abort_done", 128'(done), 128'd0);
    checkOutput("abort_mem_wr_en", 128'(memWrEn), 128'd0);
    waitUntil(s + 10);
    applyStimulus(1'b1, 32'h300, 32'h4, 5'd6, 4'b0110, s);
    memQ.push_back(mk("fr_l1", 32'h304, 128'h6, s + 2));
    memQ.push_back(mk("fr_l2", 32'h308, 128'h7, s + 3));
    doneQ.push_back(mk("fr_done", 0, 0, s + 5));
    waitUntil(s + 8);

    $display("[TB] lane sweep");
    start8 = 1'b1; start1 = 1'b1; s = cyc;
    @(posedge clk); #2;
    start8 = 1'b0; start1 = 1'b0;
    v8Q.push_back(mk("l8", 32'd2,
      128'h1010_1011_1012_FFFF_1014_1015_1016_1017, s + 9));
    d8Q.push_back(mk("l8_done", 0, 0, s + 10));
    v1Q.push_back(mk("l1", 32'd7, 128'h1020, s + 2));
    d1Q.push_back(mk("l1_done", 0, 0, s + 3));
    waitUntil(s + 14);

    // Anything still queued is an expected event that never appeared.
    checkOutput("left_mem", 128'(memQ.size()), 128'd0);
    checkOutput("left_vreg", 128'(vregQ.size()), 128'd0);
    checkOutput("left_done", 128'(doneQ.size()), 128'd0);
    checkOutput("left_l8_vreg", 128'(v8Q.size()), 128'd0);
    checkOutput("left_l8_done", 128'(d8Q.size()), 128'd0);
    checkOutput("left_l1_vreg", 128'(v1Q.size()), 128'd0);
    checkOutput("left_l1_done", 128'(d1Q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
